pau_pipe: RTL
=============

// Module: pau_pipe
// PURPOSE
//  Pipelined, handshaked successor of the parallel adder unit.
//  Per lane it computes A+B or A-B, or accumulates A+B into a saturating per-lane accumulator.
//  All NUM_LANES lanes share one valid/ready stream; lanes run in lockstep.
//  Sits between the operand fetch stream and downstream reduction/normalisation stages.
// PARAMETERS
//  NUM_LANES   4   number of parallel lanes
//  DATA_WIDTH  16  operand width per lane
//  ACC_WIDTH   24  result/accumulator width per lane; must be >= DATA_WIDTH+2
//  SIGNED      0   1: operands are two's complement; 0: operands are unsigned
// PORTS
//  clk        in   1                    clock
//  rst        in   1                    asynchronous active-high reset
//  in_valid   in   1                    operand beat valid
//  in_ready   out  1                    pipeline accepts a beat this cycle
//  mode       in   2                    00 ADD, 01 SUB, 10 ACC, 11 ACC_CLR
//  A_flat     in   NUM_LANES*DATA_WIDTH lane i at [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]
//  B_flat     in   NUM_LANES*DATA_WIDTH same packing as A_flat
//  out_valid  out  1                    result beat valid
//  out_ready  in   1                    downstream accepts the result
//  P_flat     out  NUM_LANES*ACC_WIDTH  lane i at [(i+1)*ACC_WIDTH-1 -: ACC_WIDTH], signed
//  ovf_flat   out  NUM_LANES            per-lane saturation flag for this beat
// BEHAVIOUR
//  - Reset (async, immediate): s1_valid=0, out_valid=0, P_flat=0, ovf_flat=0, all accumulators=0.
//  - Transfers: in on in_valid&&in_ready; out on out_valid&&out_ready.
//    - Holding the inputs stable while stalled is not required.
//  - Stage 1 (S1): on input transfer, register mode and the per-lane value s.
//    - s (signed, DATA_WIDTH+2): s = ext(A)-ext(B) for SUB, else ext(A)+ext(B).
//    - ext = sign-extension when SIGNED=1, zero-extension when SIGNED=0.
//  - Stage 2 (S2): on an S1->S2 move, compute and register P/ovf per mode:
//    - ADD/SUB: P = sext(s) to ACC_WIDTH; ovf=0; accumulator unchanged.
//    - ACC_CLR: acc = sext(s); P = acc; ovf=0.
//    - ACC: t = acc + sext(s), evaluated one bit wider, then clamped to
//      [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; acc = P = clamped t; ovf=1 only if clamped.
//  - Accumulator updates only on the S1->S2 move, so stalls never double-count.
//  - Latency: 2 cycles from input transfer to out_valid with no backpressure.
//    - Throughput: 1 beat/cycle.
//  - Flow control: s2_ready = !out_valid || out_ready; in_ready = !s1_valid || s2_ready.
//    - in_ready is combinational from out_ready; this is the only comb input->output path.
//  - S1->S2 move when s1_valid && s2_ready. s1_valid clears when S1 moves and no new input arrives.
//  - Simultaneous output transfer and S1 move: S2 reloads that cycle, out_valid stays 1.
//  - While out_valid && !out_ready: P_flat and ovf_flat are held bit-stable.
//  - ACC with no prior ACC_CLR since reset accumulates from 0.
//  - Saturated accumulator stays clamped until the next ACC_CLR or reset.
//    - A later ACC of opposite sign moves it off the rail with ovf=0.
//  - Reset mid-stream: in-flight beats are dropped and no out_valid is produced for them.
//    - in_ready=1 in the first cycle after rst deasserts.
// STRUCTURE
//  - pau_pkg holds:
//    - mode localparams MODE_ADD/SUB/ACC/ACC_CLR;
//    - function sat_acc(t, ACC_WIDTH) returning {ovf, clamped}.
//  - Sub-module pau_pipe_lane: per-lane S1 s-register, S2 P/ovf registers and accumulator.
//    - Lane enables come from the shared s1_load/s2_load.
//  - Top holds the valid/ready control and the generate loop over lanes.
// TESTING (DATA_WIDTH=16, ACC_WIDTH=24, NUM_LANES=4, out_ready=1 unless stated)
//  1. SIGNED=0, ADD A=0xFFFF B=0x0001, all lanes:
//     -> 2 cycles later out_valid=1, P=0x010000 in every lane, ovf=0.
//  2. SIGNED=0, SUB A=3 B=5 -> P=0xFFFFFE (-2); SIGNED=1, SUB A=0x8000 B=0x0001 -> P=0xFF7FFF.
//  3. ACC_CLR(10,20), ACC(1,2), ACC(100,0), back-to-back -> P = 30, 33, 133 on consecutive cycles.
//  4. ACC_CLR(0xFFFF,0xFFFF) then 64 ACC(0xFFFF,0xFFFF):
//     - beat 63 gives P=0x7FFF80, ovf=0;
//     - beat 64 gives P=0x7FFFFF, ovf=1.
//     - Then ACC_CLR(0,0) -> P=0, ovf=0.
//  5. out_ready=0 for 6 cycles while 4 ACC(1,0) beats are offered:
//     - exactly 2 accepted, then in_ready=0; P_flat stays stable.
//     - After release, outputs are 1,2,3,4 in order; no beat lost or duplicated.
//  6. Assert rst with both stages full:
//     - out_valid and P_flat drop to 0 in the same cycle, before the next clk edge.
//     - After release, ACC(5,0) -> P=5.

Source files
------------

// File: rtl/pau_pkg.sv
// Shared definitions for the pipelined parallel adder unit: operation
// encodings and the accumulator saturation helper.
package pau_pkg;

   // Operation select encodings carried on the mode input
   localparam logic [1:0] MODE_ADD     = 2'b00;
   localparam logic [1:0] MODE_SUB     = 2'b01;
   localparam logic [1:0] MODE_ACC     = 2'b10;
   localparam logic [1:0] MODE_ACC_CLR = 2'b11;

   // Working width of the saturation helper; any ACC_WIDTH up to SAT_W-1 fits
   localparam int SAT_W = 64;

   // Clamp a signed value to the range of an acc_width-bit two's complement
   // number. Result is {ovf, clamped}; the clamped value is sign-extended to
   // SAT_W bits so the caller keeps the low acc_width bits.
   function automatic logic [SAT_W:0] sat_acc(input logic signed [SAT_W-1:0] t,
                                               input int acc_width);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (64'sd1 <<< (acc_width - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (acc_width - 1));
      if (t > hi) begin
         return {1'b1, hi};
      end else if (t < lo) begin
         return {1'b1, lo};
      end else begin
         return {1'b0, t};
      end
   endfunction

endpackage

// File: rtl/pau_pipe_lane.sv
// One lane of the pipelined adder unit: S1 holds the extended sum or
// difference, S2 holds the lane result, its saturation flag and the
// per-lane accumulator. Load enables are shared by all lanes.
module pau_pipe_lane
   import pau_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 24,
   parameter int SIGNED     = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s1_load,
   input  logic                         s2_load,
   input  logic [1:0]                   mode_in,
   input  logic [1:0]                   mode_p1,
   input  logic [DATA_WIDTH-1:0]        a,
   input  logic [DATA_WIDTH-1:0]        b,
   output logic signed [ACC_WIDTH-1:0]  p,
   output logic                         ovf
);

   localparam int SW = DATA_WIDTH + 2;

   logic signed [SW-1:0]        a_ext;
   logic signed [SW-1:0]        b_ext;
   logic signed [SW-1:0]        s_p0;
   logic signed [SW-1:0]        s_p1;
   logic signed [ACC_WIDTH-1:0] s_sx;
   logic signed [ACC_WIDTH:0]   t_wide;
   logic [SAT_W:0]              sat_res;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [ACC_WIDTH-1:0] acc_nxt;
   logic signed [ACC_WIDTH-1:0] p_nxt;
   logic                        ovf_nxt;
   logic                        unused_sat_hi;

   // Operand extension and add/subtract ahead of the S1 register
   always_comb begin
      if (SIGNED != 0) begin
         a_ext = {{2{a[DATA_WIDTH-1]}}, a};
         b_ext = {{2{b[DATA_WIDTH-1]}}, b};
      end else begin
         a_ext = {2'b00, a};
         b_ext = {2'b00, b};
      end
      if (mode_in == MODE_SUB) begin
         s_p0 = a_ext - b_ext;
      end else begin
         s_p0 = a_ext + b_ext;
      end
   end

   // ---- stage 1: extended sum/difference, captured on input transfer ----
   always_ff @(posedge clk) begin
      if (s1_load) begin
         s_p1 <= s_p0;
      end
   end

   // Result selection and saturating accumulate; one extra bit so the sum cannot wrap
   always_comb begin
      s_sx    = ACC_WIDTH'(s_p1);
      t_wide  = (ACC_WIDTH + 1)'(acc) + (ACC_WIDTH + 1)'(s_sx);
      sat_res = sat_acc(SAT_W'(t_wide), ACC_WIDTH);
      p_nxt   = s_sx;
      acc_nxt = acc;
      ovf_nxt = 1'b0;
      case (mode_p1)
         MODE_ACC_CLR: begin
            acc_nxt = s_sx;
         end
         MODE_ACC: begin
            acc_nxt = sat_res[ACC_WIDTH-1:0];
            p_nxt   = sat_res[ACC_WIDTH-1:0];
            ovf_nxt = sat_res[SAT_W];
         end
         default: begin
         end
      endcase
   end

   // Upper helper bits are only sign copies of the clamped value
   assign unused_sat_hi = ^sat_res[SAT_W-1:ACC_WIDTH];

   // ---- stage 2: result, flag and accumulator, updated only on the S1->S2 move ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         p   <= '0;
         ovf <= 1'b0;
      end else if (s2_load) begin
         acc <= acc_nxt;
         p   <= p_nxt;
         ovf <= ovf_nxt;
      end
   end

endmodule

// File: rtl/pau_pipe.sv
// Two-stage handshaked parallel adder unit. All lanes run in lockstep on a
// single valid/ready stream; this module owns the stage valids and the
// backpressure chain and replicates the lane datapath.
module pau_pipe
   import pau_pkg::*;
#(
   parameter int NUM_LANES  = 4,
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 24,
   parameter int SIGNED     = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [1:0]                      mode,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] A_flat,
   input  logic [NUM_LANES*DATA_WIDTH-1:0] B_flat,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_LANES*ACC_WIDTH-1:0]  P_flat,
   output logic [NUM_LANES-1:0]            ovf_flat
);

   logic       vld_p1;
   logic       vld_p2;
   logic [1:0] mode_p1;
   logic       s2_ready;
   logic       s1_load;
   logic       s2_load;

   // S2 frees up when empty or being drained; S1 likewise chains off S2.
   // in_ready is the single combinational path from an input (out_ready).
   assign s2_ready  = !vld_p2 || out_ready;
   assign in_ready  = !vld_p1 || s2_ready;
   assign s1_load   = in_valid && in_ready;
   assign s2_load   = vld_p1 && s2_ready;
   assign out_valid = vld_p2;

   // ---- stage 1: valid and operation follow the accepted beat ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         mode_p1 <= MODE_ADD;
      end else begin
         if (s1_load) begin
            vld_p1  <= 1'b1;
            mode_p1 <= mode;
         end else if (s2_load) begin
            vld_p1  <= 1'b0;
         end
      end
   end

   // ---- stage 2: valid reloads on an S1 move even while a result leaves ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2 <= 1'b0;
      end else if (s2_load) begin
         vld_p2 <= 1'b1;
      end else if (out_ready) begin
         vld_p2 <= 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      pau_pipe_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .ACC_WIDTH  (ACC_WIDTH),
         .SIGNED     (SIGNED)
      ) u_lane (
         .clk     (clk),
         .rst     (rst),
         .s1_load (s1_load),
         .s2_load (s2_load),
         .mode_in (mode),
         .mode_p1 (mode_p1),
         .a       (A_flat[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]),
         .b       (B_flat[(i+1)*DATA_WIDTH-1 -: DATA_WIDTH]),
         .p       (P_flat[(i+1)*ACC_WIDTH-1 -: ACC_WIDTH]),
         .ovf     (ovf_flat[i])
      );
   end

endmodule
